// File: rtl/pipelined_rca_pkg.sv
// pipelined_rca_pkg: shared slice sizing and per-stage control record
package pipelined_rca_pkg;
  typedef struct packed {
    logic vld;
    logic carry;
  } stage_ctl_t;
  function automatic int chunk_width(input int word_width, input int stage_count);
    return word_width / stage_count;
  endfunction
endpackage

// File: rtl/RCA_M.sv
// RCA_M: combinational ripple-carry adder slice
module RCA_M #(
  parameter int word_width = 8
) (
  input  logic [word_width-1:0] a,
  input  logic [word_width-1:0] b,
  input  logic                  c_in,
  output logic [word_width-1:0] s,
  output logic                  c_out
);
  assign {c_out, s} = {1'b0, a} + {1'b0, b} + (word_width + 1)'(c_in);
endmodule

// File: rtl/pipelined_rca_stage.sv
// pipelined_rca_stage: one registered adder slice with elastic valid/ready (OVF under PIPELINED_RCA_OVF_EN)
module pipelined_rca_stage import pipelined_rca_pkg::*; #(
  parameter int word_width  = 32,
  parameter int stage_count = 4,
  parameter int idx         = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  stage_ctl_t            up_ctl,
  input  logic [word_width-1:0] up_a,
  input  logic [word_width-1:0] up_b,
  input  logic [word_width-1:0] up_r,
  input  logic                  dn_rdy,
  output stage_ctl_t            ctl,
  output logic [word_width-1:0] a,
  output logic [word_width-1:0] b,
  output logic [word_width-1:0] r,
  output logic                  rdy
`ifdef PIPELINED_RCA_OVF_EN
  ,
  output logic                  ovf
`endif
);
  localparam int cw = chunk_width(word_width, stage_count);
  logic [cw-1:0] s;
  logic co;
  logic [word_width-1:0] r_n;
  logic unused_ok;
  RCA_M #(.word_width(cw)) u_rca (
    .a(up_a[idx*cw +: cw]),
    .b(up_b[idx*cw +: cw]),
    .c_in(up_ctl.carry),
    .s(s),
    .c_out(co)
  );
  assign rdy = !ctl.vld | dn_rdy;
  assign unused_ok = ^up_r[idx*cw +: cw];
  // splice this slice's sum into the partially completed result word
  always_comb begin
    r_n = up_r;
    r_n[idx*cw +: cw] = s;
  end
  // advance when downstream frees this slot; data only loads with a real op so stalls stay bit-stable
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl <= '0;
      a   <= '0;
      b   <= '0;
      r   <= '0;
    end else begin
      if (rdy) ctl.vld <= up_ctl.vld;
      if (rdy & up_ctl.vld) begin
        ctl.carry <= co;
        a         <= up_a;
        b         <= up_b;
        r         <= r_n;
      end
    end
  end
`ifdef PIPELINED_RCA_OVF_EN
  // signed overflow: carry into the slice top bit xor carry out of it
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else if (rdy & up_ctl.vld) ovf <= up_a[idx*cw+cw-1] ^ up_b[idx*cw+cw-1] ^ s[cw-1] ^ co;
  end
`endif
endmodule

// File: rtl/pipelined_rca.sv
// pipelined_rca: stage_count-deep pipelined add/sub with full backpressure (OVF under PIPELINED_RCA_OVF_EN)
module pipelined_rca import pipelined_rca_pkg::*; #(
  parameter int word_width  = 32,
  parameter int stage_count = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [word_width-1:0] A,
  input  logic [word_width-1:0] B,
  input  logic                  C_IN,
  input  logic                  SUB,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [word_width-1:0] R,
  output logic                  C_OUT
`ifdef PIPELINED_RCA_OVF_EN
  ,
  output logic                  OVF
`endif
);
  if (word_width % stage_count != 0) begin : g_chk
    $error("pipelined_rca: word_width must be a multiple of stage_count");
  end
  stage_ctl_t ctl [stage_count+1];
  logic [word_width-1:0] a_s [stage_count+1];
  logic [word_width-1:0] b_s [stage_count+1];
  logic [word_width-1:0] r_s [stage_count+1];
  logic rdy [stage_count+1];
  logic unused_ok;
`ifdef PIPELINED_RCA_OVF_EN
  logic [stage_count-1:0] ovf_s;
  logic unused_ovf;
  assign OVF = ovf_s[stage_count-1];
  assign unused_ovf = ^ovf_s;
`endif
  assign ctl[0] = '{vld: IN_VALID, carry: SUB | C_IN};
  assign a_s[0] = A;
  assign b_s[0] = B ^ {word_width{SUB}};
  assign r_s[0] = '0;
  assign rdy[stage_count] = OUT_READY;
  genvar i;
  for (i = 0; i < stage_count; i++) begin : g_stage
    pipelined_rca_stage #(.word_width(word_width), .stage_count(stage_count), .idx(i)) u_stage (
      .clk(CLK),
      .rst(RST),
      .up_ctl(ctl[i]),
      .up_a(a_s[i]),
      .up_b(b_s[i]),
      .up_r(r_s[i]),
      .dn_rdy(rdy[i+1]),
      .ctl(ctl[i+1]),
      .a(a_s[i+1]),
      .b(b_s[i+1]),
      .r(r_s[i+1]),
      .rdy(rdy[i])
`ifdef PIPELINED_RCA_OVF_EN
      ,
      .ovf(ovf_s[i])
`endif
    );
  end
  assign IN_READY  = rdy[0];
  assign OUT_VALID = ctl[stage_count].vld;
  assign C_OUT     = ctl[stage_count].carry;
  assign R         = r_s[stage_count];
  assign unused_ok = ^{a_s[stage_count], b_s[stage_count]};
endmodule

// File: tb/tb_pipelined_rca.sv
// tb_pipelined_rca: directed and scoreboarded checks of pipelined_rca at 8/4 and 32/4
module tb_pipelined_rca;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST;
  logic iv8, ir8, ov8, or8, cin8, sub8, c8;
  logic [7:0] a8, b8, r8;
  logic iv32, ir32, ov32, or32, cin32, sub32, c32;
  logic [31:0] a32, b32, r32;
`ifdef PIPELINED_RCA_OVF_EN
  logic ovf8, ovf32;
`endif
  int checks = 0;
  int errors = 0;

  pipelined_rca #(.word_width(8), .stage_count(4)) u8 (
    .CLK(CLK), .RST(RST), .IN_VALID(iv8), .IN_READY(ir8), .A(a8), .B(b8), .C_IN(cin8), .SUB(sub8),
    .OUT_VALID(ov8), .OUT_READY(or8), .R(r8), .C_OUT(c8)
`ifdef PIPELINED_RCA_OVF_EN
    , .OVF(ovf8)
`endif
  );

  pipelined_rca #(.word_width(32), .stage_count(4)) u32 (
    .CLK(CLK), .RST(RST), .IN_VALID(iv32), .IN_READY(ir32), .A(a32), .B(b32), .C_IN(cin32), .SUB(sub32),
    .OUT_VALID(ov32), .OUT_READY(or32), .R(r32), .C_OUT(c32)
`ifdef PIPELINED_RCA_OVF_EN
    , .OVF(ovf32)
`endif
  );

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    return {1'b0, a} + {1'b0, sub ? ~b : b} + 33'(sub ? 1'b1 : cin);
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    iv8 = 0; or8 = 1; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    iv32 = 0; or32 = 1; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0;
    tick;
    tick;
    RST = 1'b0;
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_ov8: got %b want 0", ov8); end
    checks++; if (r8 !== 8'h00) begin errors++; $display("FAIL reset_r8: got %h want 00", r8); end
    checks++; if (c8 !== 1'b0) begin errors++; $display("FAIL reset_c8: got %b want 0", c8); end
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL reset_ir8: got %b want 1", ir8); end
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL reset_ov32: got %b want 0", ov32); end
    checks++; if ({c32, r32} !== 33'h0) begin errors++; $display("FAIL reset_r32: got %h want 0", {c32, r32}); end
    checks++; if (ir32 !== 1'b1) begin errors++; $display("FAIL reset_ir32: got %b want 1", ir32); end
`ifdef PIPELINED_RCA_OVF_EN
    checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL reset_ovf8: got %b want 0", ovf8); end
`endif
  endtask

  task automatic test_add8(input string name, input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic sub, input logic [7:0] er, input logic ec);
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; iv8 = 1'b1;
    tick;
    iv8 = 1'b0;
    repeat (3) begin
      checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL %s_early: OUT_VALID got %b want 0", name, ov8); end
      tick;
    end
    checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b want 1", name, ov8); end
    checks++; if (r8 !== er) begin errors++; $display("FAIL %s_r: got %h want %h", name, r8, er); end
    checks++; if (c8 !== ec) begin errors++; $display("FAIL %s_cout: got %b want %b", name, c8, ec); end
  endtask

  task automatic test_ovf;
`ifdef PIPELINED_RCA_OVF_EN
    test_add8("ovf_sub", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1);
    checks++; if (ovf8 !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf8); end
    test_add8("ovf_clr", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
    checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", ovf8); end
`else
    test_add8("sub_wrap", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1);
`endif
  endtask

  task automatic test_carry_chain;
    a32 = 32'hFFFF_FFFF; b32 = 32'h1; cin32 = 0; sub32 = 0; iv32 = 1'b1;
    tick;
    iv32 = 1'b0;
    repeat (3) begin
      checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL chain_early: OUT_VALID got %b want 0", ov32); end
      tick;
    end
    checks++; if (ov32 !== 1'b1) begin errors++; $display("FAIL chain_valid: got %b want 1", ov32); end
    checks++; if ({c32, r32} !== 33'h1_0000_0000) begin errors++; $display("FAIL chain_r: got %h want 100000000", {c32, r32}); end
`ifdef PIPELINED_RCA_OVF_EN
    checks++; if (ovf32 !== 1'b0) begin errors++; $display("FAIL chain_ovf: got %b want 0", ovf32); end
`endif
    tick;
  endtask

  task automatic test_back_to_back;
    logic [32:0] q[$];
    logic [32:0] e;
    or32 = 1'b1;
    for (int i = 0; i < 105; i++) begin
      if (i < 100) begin
        a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1)); iv32 = 1'b1;
      end else iv32 = 1'b0;
      #1;
      checks++; if (ov32 !== (i >= 4 && i < 104)) begin errors++; $display("FAIL b2b_valid: cycle %0d got %b", i, ov32); end
      if (ov32) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL b2b_dup: result %h with empty scoreboard", {c32, r32}); end
        else begin
          e = q.pop_front();
          if ({c32, r32} !== e) begin errors++; $display("FAIL b2b_r: cycle %0d got %h want %h", i, {c32, r32}, e); end
        end
      end
      if (iv32 && ir32) q.push_back(model(a32, b32, cin32, sub32));
      tick;
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL b2b_lost: %0d left want 0", q.size()); end
  endtask

  task automatic test_random_stall;
    logic [32:0] q[$];
    logic [32:0] e, prev;
    logic prev_stall = 1'b0;
    prev = '0;
    for (int i = 0; i < 600; i++) begin
      iv32 = 1'($urandom_range(0, 1)); or32 = 1'($urandom_range(0, 1));
      a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
      #1;
      checks++; if (ir32 !== !(q.size() == 4 && !or32)) begin errors++; $display("FAIL rnd_ready: got %b occupancy %0d out_ready %b", ir32, q.size(), or32); end
      if (prev_stall) begin
        checks++; if ({c32, r32} !== prev) begin errors++; $display("FAIL rnd_stall: got %h want %h", {c32, r32}, prev); end
      end
      if (ov32 && or32) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rnd_dup: result %h with empty scoreboard", {c32, r32}); end
        else begin
          e = q.pop_front();
          if ({c32, r32} !== e) begin errors++; $display("FAIL rnd_r: got %h want %h", {c32, r32}, e); end
        end
      end
      if (iv32 && ir32) q.push_back(model(a32, b32, cin32, sub32));
      prev_stall = ov32 && !or32;
      prev = {c32, r32};
      tick;
    end
    iv32 = 1'b0; or32 = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      #1;
      if (ov32) begin
        e = q.pop_front();
        checks++; if ({c32, r32} !== e) begin errors++; $display("FAIL rnd_drain: got %h want %h", {c32, r32}, e); end
      end
      tick;
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_lost: %0d left want 0", q.size()); end
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL rnd_extra: OUT_VALID got %b want 0", ov32); end
  endtask

  task automatic test_reset_flight;
    or32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a32 = 32'h1000 + i; b32 = 32'h22; cin32 = 1'b1; sub32 = 1'b0; iv32 = 1'b1;
      tick;
    end
    iv32 = 1'b0;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ov32); end
    checks++; if ({c32, r32} !== 33'h0) begin errors++; $display("FAIL rst_r: got %h want 0", {c32, r32}); end
    checks++; if (ir32 !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ir32); end
    repeat (8) begin
      tick;
      checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL rst_stale: OUT_VALID got %b want 0", ov32); end
    end
  endtask

  initial begin
    test_reset;
    test_add8("add_0f01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0);
    test_add8("sub_5m7", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
    test_add8("add_cin", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    test_ovf;
    test_carry_chain;
    test_back_to_back;
    test_random_stall;
    test_reset_flight;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
